// File: rtl/anode_scan_pkg.sv
// Shared types and helpers for the anode scanner.
// The FSM state enum, the all-off anode constant, the digit index type and
// the cyclic next-digit search are defined here.
package anode_scan_pkg;

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef logic [1:0] dig_t;

  typedef struct packed {
    logic found;
    dig_t idx;
  } search_t;

  // First enabled digit after cur (cyclic); cur itself is tried last.
  function automatic search_t find_next(input logic [3:0] mask, input dig_t cur);
    search_t r;
    dig_t    c;
    r.found = 1'b0;
    r.idx   = cur;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int k = 4; k >= 1; k--) begin
      c = cur + dig_t'(k);
      if (mask[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

  // Active-low one-cold drive for digit d.
  function automatic logic [3:0] drive(input dig_t d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Slot counter for the anode scanner: counts 0..REFRESH_DIV-1 while enabled,
// clears when disabled or in reset, and flags the last cycle of each slot.
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 100000,
  parameter int CW          = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  assign tick = enable && (cnt == LAST);

  // Slot counter: restart from 0 whenever scanning is off or the slot ends.
  always_ff @(posedge clk) begin
    if (reset || !enable) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/anode_scanner.sv
// Multiplexed seven-segment anode scanner.
// Rotates through the digits enabled in digit_en, one slot of REFRESH_DIV
// cycles per digit, driving an active-low one-cold anode bus.
// Optional feature macro ANODE_GAP_EN: blanks the anode for the first
// GAP_LEN cycles of every slot to suppress ghosting between digits.
module anode_scanner
  import anode_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit_en,
  output logic [3:0] anode,
  output logic [1:0] digit_sel,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

`ifdef ANODE_GAP_EN
  localparam bit GAP_ON = (GAP_LEN > 0);
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic [CW-1:0] cnt;
  logic          tick;
  state_t        state;
  search_t       nxt;

  refresh_tick_gen #(.REFRESH_DIV(REFRESH_DIV), .CW(CW)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .cnt    (cnt),
    .tick   (tick)
  );

  assign nxt = find_next(digit_en, digit_sel);

  // Scan FSM: advance on tick, blank on disable/clear, optional gap->show.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      anode      <= ANODE_OFF;
      digit_sel  <= 2'd3;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      anode      <= ANODE_OFF;
      frame_tick <= 1'b0;
    end else if (tick) begin
      if (nxt.found) begin
        digit_sel  <= nxt.idx;
        // Wrap (or single-digit repeat) marks the start of a new frame.
        frame_tick <= (nxt.idx <= digit_sel);
        if (GAP_ON) begin
          state <= GAP;
          anode <= ANODE_OFF;
        end else begin
          state <= SHOW;
          anode <= drive(nxt.idx);
        end
      end else begin
        state      <= IDLE;
        anode      <= ANODE_OFF;
        frame_tick <= 1'b0;
      end
    end else begin
      frame_tick <= 1'b0;
      if (state != IDLE && !digit_en[digit_sel]) begin
        // Current digit withdrawn mid-slot: go dark until the next tick.
        state <= IDLE;
        anode <= ANODE_OFF;
      end else if (GAP_ON && state == GAP && cnt == CW'(GAP_LEN - 1)) begin
        state <= SHOW;
        anode <= drive(digit_sel);
      end
    end
  end

endmodule

// File: tb/tb_anode_scanner.sv
// Randomized scoreboard bench for anode_scanner (REFRESH_DIV=4, GAP_LEN=1).
// Build with +define+ANODE_GAP_EN to exercise the blanking gap.
module tb_anode_scanner;

  localparam int DIV  = 4;
  localparam int GLEN = 1;
`ifdef ANODE_GAP_EN
  localparam int TB_GAP = GLEN;
`else
  localparam int TB_GAP = 0;
`endif
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [3:0] digit_en;
  logic [3:0] anode;
  logic [1:0] digit_sel;
  logic       frame_tick;

  anode_scanner #(.REFRESH_DIV(DIV), .GAP_LEN(GLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digit_en   (digit_en),
    .anode      (anode),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] anode;
    logic [1:0] sel;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   started = 0;

  // Reference model: slot position, selected digit, whether it is lit.
  int m_cnt = 0;
  int m_sel = 3;
  bit m_lit = 0;
  bit m_frame = 0;

  function automatic exp_t model_out();
    exp_t e;
    e.sel   = 2'(m_sel);
    e.frame = m_frame;
    if (m_lit && m_cnt >= TB_GAP) e.anode = 4'hF & ~(4'd1 << m_sel);
    else                          e.anode = 4'hF;
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit en, input logic [3:0] de);
    int j;
    if (rst) begin
      m_cnt = 0; m_sel = 3; m_lit = 0; m_frame = 0;
    end else if (!en) begin
      m_cnt = 0; m_lit = 0; m_frame = 0;
    end else if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      j = -1;
      for (int k = 1; k <= 4 && j < 0; k++)
        if (de[(m_sel + k) % 4]) j = (m_sel + k) % 4;
      if (j >= 0) begin
        m_frame = (j <= m_sel);
        m_sel   = j;
        m_lit   = 1;
      end else begin
        m_frame = 0;
        m_lit   = 0;
      end
    end else begin
      m_cnt   = m_cnt + 1;
      m_frame = 0;
      if (!de[m_sel]) m_lit = 0;
    end
  endtask

  // Monitor: one expected entry per clock edge once stimulus has begun.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (anode !== e.anode) begin
          fails++;
          $display("FAIL anode t=%0t got %b want %b", $time, anode, e.anode);
        end
        tests++;
        if (digit_sel !== e.sel) begin
          fails++;
          $display("FAIL digit_sel t=%0t got %0d want %0d", $time, digit_sel, e.sel);
        end
        tests++;
        if (frame_tick !== e.frame) begin
          fails++;
          $display("FAIL frame_tick t=%0t got %b want %b", $time, frame_tick, e.frame);
        end
      end else if (started) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty t=%0t got 0 entries want 1", $time);
      end
    end
  end

  // Stimulus: directed warm-up phases, then randomized traffic.
  initial begin
    logic [3:0] pats [9];
    int         off_left = 0;
    bit         rst;
    pats = '{4'hF, 4'h5, 4'hA, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h3};
    reset = 1'b1; enable = 1'b1; digit_en = 4'hF;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst = (c < 2) || ($urandom_range(0, 299) == 0);
      if (c < 40)       digit_en = 4'hF;
      else if (c < 80)  digit_en = 4'h5;
      else if (c == 85) digit_en = 4'h0;
      else if (c >= 100 && $urandom_range(0, 39) == 0)
        digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : pats[$urandom_range(0, 8)];
      else if (c > 85 && c < 100) digit_en = 4'h4;
      if (c >= 100) begin
        if (off_left > 0) off_left--;
        else if ($urandom_range(0, 79) == 0) off_left = $urandom_range(1, 5);
      end
      enable = (off_left == 0);
      reset  = rst;
      model_step(rst, enable, digit_en);
      q.push_back(model_out());
      started = 1;
    end
    @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d entries want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/anode_scanner.md
ANODE_SCANNER -- requirements
Module: anode_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (min 2).
REQ-002 Parameter GAP_LEN, default 4, blank cycles at the start of each slot (used only with ANODE_GAP_EN; must be less than REFRESH_DIV).
REQ-003 Port clk input 1: single clock; all state on rising edge.
REQ-004 Port reset input 1: synchronous, active-high.
REQ-005 Port enable input 1: 1 = scanning; 0 = display off.
REQ-006 Port digit_en input 4: per-digit include mask, bit i = digit i.
REQ-007 Port anode output 4: active-low one-cold digit drive; 4'b1111 = all off. Feeds the seven-segment decoder's anode input.
REQ-008 Port digit_sel output 2: index of the currently scanned digit.
REQ-009 Port frame_tick output 1: one-cycle pulse on rotation wrap.

Function
REQ-010 States: IDLE (anode off), GAP (anode off, slot running), SHOW (anode driven).
REQ-011 Slot counter cnt counts 0..REFRESH_DIV-1 while enable=1; tick = enable and cnt==REFRESH_DIV-1; cnt wraps to 0 on tick.
REQ-012 On tick: digit_sel <= first index j with digit_en[j]=1, searched cyclically starting at digit_sel+1 (mod 4); the search includes digit_sel itself last.
REQ-013 On tick with a found index: anode <= all ones except bit j=0; state <= SHOW (or GAP, see REQ-021).
REQ-014 frame_tick = 1 for the cycle after the tick iff the new index <= the old index; otherwise 0.
REQ-015 With a single enabled digit, every tick asserts frame_tick and anode is unchanged.
REQ-016 digit_en==0 at a tick: anode <= 4'b1111, digit_sel held, frame_tick=0, state <= IDLE.
REQ-017 Clearing the currently shown digit's digit_en bit mid-slot: anode <= 4'b1111 on the next edge; rotation resumes at the next tick.
REQ-018 enable=0: on the next edge cnt <= 0, anode <= 4'b1111, state <= IDLE, frame_tick <= 0, digit_sel held.
REQ-019 enable rising: counting restarts from cnt=0; the first tick advances from the held digit_sel.
REQ-020 Latency: anode and digit_sel are registered and change exactly one edge after the tick condition; they never change between ticks except per REQ-017/018.

Configuration
REQ-021 Macro ANODE_GAP_EN defined: for cnt 0..GAP_LEN-1 of each slot, state=GAP and anode=4'b1111; SHOW drives the anode from cnt=GAP_LEN. digit_sel and frame_tick timing are unchanged.
REQ-022 ANODE_GAP_EN undefined: no GAP state; anode is driven for the entire slot; GAP_LEN is ignored.

Reset
REQ-023 Reset takes priority over all other inputs and has effect on the next edge: cnt=0, digit_sel=2'd3, anode=4'b1111, frame_tick=0, state=IDLE.
REQ-024 Reset asserted mid-slot or mid-gap aborts the slot; the first tick after release selects the lowest enabled digit and asserts frame_tick.

Structure
REQ-025 Shared package anode_scan_pkg holds the state_t enum (IDLE, GAP, SHOW), the ANODE_OFF=4'b1111 constant and the digit index type.
REQ-026 One sub-module, refresh_tick_gen, holds the slot counter and produces tick and cnt; the FSM and the search logic remain in anode_scanner.

Verification (REFRESH_DIV=4, GAP_LEN=1)
REQ-027 Reset, enable=1, digit_en=4'b1111 -> anode sequence 1110,1101,1011,0111,1110, each held 4 cycles; frame_tick pulses only with the 0111->1110 change (and at the first tick after reset).
REQ-028 digit_en=4'b0101 -> anode alternates 1110,1011; frame_tick pulses with each 1011->1110 change.
REQ-029 digit_en cleared to 4'b0000 mid-slot -> anode=1111 on the next edge; at the next tick state=IDLE and digit_sel is held.
REQ-030 enable low for 3 cycles during digit 2 -> anode=1111 and cnt=0; after re-enable, 4 cycles later anode=0111.
REQ-031 Reset pulse mid-slot while showing digit 1 -> anode=1111 and digit_sel=3 next edge; the first tick after release gives anode=1110 and frame_tick=1.
REQ-032 With ANODE_GAP_EN: every slot shows anode=1111 at cnt=0 and the digit drive for cnt 1..3; without the macro, the digit is driven for all 4 cycles.
